// File: rtl/bilinear_pkg.sv
// Shared types and helpers for the bilinear read arbiter.
//   lane_id_t  : lane index, wide enough for up to MAX_LANES lanes
//   rsp_slot_t : one response-pipeline stage {vld, id}
//   rr_pick    : round-robin winner search starting after the last grant
package bilinear_pkg;

    localparam int unsigned MAX_LANES = 8;
    localparam int unsigned LANE_ID_W = $clog2(MAX_LANES);

    // Sized for the largest supported lane count so one package serves every instance.
    typedef logic [LANE_ID_W-1:0] lane_id_t;

    typedef struct packed {
        logic     vld;
        lane_id_t id;
    } rsp_slot_t;

    // First valid lane found scanning (last+1) mod n_lanes upward; returns last if none valid.
    function automatic lane_id_t rr_pick(input logic [MAX_LANES-1:0] valid,
                                         input lane_id_t              last,
                                         input int unsigned           n_lanes);
        lane_id_t    pick;
        lane_id_t    sel;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_LANES; k++) begin
            if (k <= n_lanes) begin
                // last < n_lanes and k <= n_lanes, so one subtraction wraps the index.
                idx = 32'(last) + k;
                if (idx >= n_lanes) begin
                    idx = idx - n_lanes;
                end
                sel = lane_id_t'(idx);
                if (!found && valid[sel]) begin
                    pick  = sel;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bilinear_rsp_pipe.sv
// Response pipeline: DEPTH-stage shift register of rsp_slot_t with flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : clears every stage at the next edge
//   slot_in    : slot loaded into stage 0 each cycle
//   slot_out   : last stage, i.e. slot_in delayed by DEPTH cycles
module bilinear_rsp_pipe
    import bilinear_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  rsp_slot_t slot_in,
    output rsp_slot_t slot_out
);

    rsp_slot_t [DEPTH-1:0] slots_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
        end else if (flush) begin
            slots_q <= '0;
        end else begin
            slots_q[0] <= slot_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                slots_q[i] <= slots_q[i-1];
            end
        end
    end

    assign slot_out = slots_q[DEPTH-1];

endmodule

// File: rtl/bilinear_rd_arbiter.sv
// Round-robin read arbiter sharing a two-port wide image memory between N_LANES
// bilinear engines, with bounded grant locking and per-lane response routing.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_flush               : drop in-flight responses, block grants this cycle
//   req_valid/req_lock    : per-lane request and lock request
//   req_addr0/req_addr1   : per-lane addresses, lane i at [i*AW +: AW]
//   req_ready             : one-hot combinational grant
//   rsp_valid             : one-hot response strobe, RD_LAT cycles after accept
//   rsp_data0/rsp_data1   : memory read data broadcast to all lanes
//   mem_re/mem_raddr0/1   : memory read port drive
//   mem_rdata0/1          : memory read data
//   o_stall_count         : cycles with a valid request left ungranted
//   o_lane_grants         : per-lane accept counts (BILINEAR_ARB_STATS_EN only)
//   o_conflict_count      : cycles with >=2 valid requests (BILINEAR_ARB_STATS_EN only)
// Build option: define BILINEAR_ARB_STATS_EN to build the statistics counters;
// otherwise those outputs are tied to zero.
module bilinear_rd_arbiter
    import bilinear_pkg::*;
#(
    parameter int unsigned N_LANES  = 2,
    parameter int unsigned AW       = 10,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic [N_LANES-1:0]    req_valid,
    input  logic [N_LANES-1:0]    req_lock,
    input  logic [N_LANES*AW-1:0] req_addr0,
    input  logic [N_LANES*AW-1:0] req_addr1,
    output logic [N_LANES-1:0]    req_ready,
    output logic [N_LANES-1:0]    rsp_valid,
    output logic [31:0]           rsp_data0,
    output logic [31:0]           rsp_data1,
    output logic                  mem_re,
    output logic [AW-1:0]         mem_raddr0,
    output logic [AW-1:0]         mem_raddr1,
    input  logic [31:0]           mem_rdata0,
    input  logic [31:0]           mem_rdata1,
    output logic [31:0]           o_stall_count,
    output logic [N_LANES*32-1:0] o_lane_grants,
    output logic [31:0]           o_conflict_count
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    logic [MAX_LANES-1:0] valid_pad;
    logic [MAX_LANES-1:0] lock_pad;
    logic                 any_valid;
    logic                 accept;
    logic                 lock_win;
    lane_id_t             winner;

    lane_id_t             last_grant_q;
    cnt_t                 lock_cnt_q;
    logic                 lock_active_q;
    logic [31:0]          stall_q;

    rsp_slot_t            slot_in;
    rsp_slot_t            slot_out;

    // Arbitration
    always_comb begin
        valid_pad                = '0;
        valid_pad[N_LANES-1:0]   = req_valid;
        lock_pad                 = '0;
        lock_pad[N_LANES-1:0]    = req_lock;
        any_valid                = |req_valid;
        accept                   = any_valid && !i_flush;
        // Owner keeps the grant only while its lock run is below LOCK_MAX.
        lock_win = lock_active_q && valid_pad[last_grant_q] && (lock_cnt_q < cnt_t'(LOCK_MAX));
        winner   = lock_win ? last_grant_q : rr_pick(valid_pad, last_grant_q, N_LANES);
        for (int unsigned i = 0; i < N_LANES; i++) begin
            req_ready[i] = accept && (winner == lane_id_t'(i));
        end
    end

    // Memory drive: winner's addresses on accept, zero when idle
    always_comb begin
        mem_re     = accept;
        mem_raddr0 = '0;
        mem_raddr1 = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (accept && (winner == lane_id_t'(i))) begin
                mem_raddr0 = req_addr0[i*AW +: AW];
                mem_raddr1 = req_addr1[i*AW +: AW];
            end
        end
    end

    // Lock tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= lane_id_t'(N_LANES - 1);
            lock_cnt_q    <= '0;
            lock_active_q <= 1'b0;
        end else if (accept) begin
            last_grant_q <= winner;
            if (lock_win && lock_pad[winner]) begin
                lock_cnt_q <= lock_cnt_q + cnt_t'(1);
            end else begin
                // A fresh run starts here, even when rotation lands back on the same lane.
                lock_cnt_q    <= cnt_t'(1);
                lock_active_q <= lock_pad[winner];
            end
        end else begin
            // Idle or flush cycle: lock is released, last_grant is kept.
            lock_cnt_q    <= '0;
            lock_active_q <= 1'b0;
        end
    end

    // Response pipeline
    always_comb begin
        slot_in.vld = accept;
        slot_in.id  = winner;
    end

    bilinear_rsp_pipe #(
        .DEPTH (RD_LAT)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (i_flush),
        .slot_in  (slot_in),
        .slot_out (slot_out)
    );

    // A response emerging during a flush cycle is in flight too, so it is dropped.
    always_comb begin
        for (int unsigned i = 0; i < N_LANES; i++) begin
            rsp_valid[i] = slot_out.vld && !i_flush && (slot_out.id == lane_id_t'(i));
        end
    end

    assign rsp_data0 = mem_rdata0;
    assign rsp_data1 = mem_rdata1;

    // Stall counter: some valid lane was not covered by this cycle's grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (any_valid && ((req_valid & ~req_ready) != '0)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign o_stall_count = stall_q;

`ifdef BILINEAR_ARB_STATS_EN
    logic [N_LANES-1:0][31:0] lane_grants_q;
    logic [31:0]              conflict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_grants_q <= '0;
            conflict_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    lane_grants_q[i] <= lane_grants_q[i] + 32'd1;
                end
            end
            if ($countones(req_valid) >= 2) begin
                conflict_q <= conflict_q + 32'd1;
            end
        end
    end

    assign o_lane_grants    = lane_grants_q;
    assign o_conflict_count = conflict_q;
`else
    assign o_lane_grants    = '0;
    assign o_conflict_count = '0;
`endif

endmodule

// File: tb/tb_bilinear_rd_arbiter.sv
// Directed self-checking bench for bilinear_rd_arbiter (N_LANES=2, RD_LAT=2, LOCK_MAX=4).
module tb_bilinear_rd_arbiter;

    localparam int unsigned N_LANES  = 2;
    localparam int unsigned AW       = 10;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned LOCK_MAX = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  i_flush;
    logic [N_LANES-1:0]    req_valid;
    logic [N_LANES-1:0]    req_lock;
    logic [N_LANES*AW-1:0] req_addr0;
    logic [N_LANES*AW-1:0] req_addr1;
    logic [N_LANES-1:0]    req_ready;
    logic [N_LANES-1:0]    rsp_valid;
    logic [31:0]           rsp_data0;
    logic [31:0]           rsp_data1;
    logic                  mem_re;
    logic [AW-1:0]         mem_raddr0;
    logic [AW-1:0]         mem_raddr1;
    logic [31:0]           mem_rdata0;
    logic [31:0]           mem_rdata1;
    logic [31:0]           o_stall_count;
    logic [N_LANES*32-1:0] o_lane_grants;
    logic [31:0]           o_conflict_count;

    int checks = 0;
    int errors = 0;

`ifdef BILINEAR_ARB_STATS_EN
    localparam logic [63:0] EXP_GRANTS   = {32'd5, 32'd5};
    localparam logic [31:0] EXP_CONFLICT = 32'd10;
`else
    localparam logic [63:0] EXP_GRANTS   = 64'd0;
    localparam logic [31:0] EXP_CONFLICT = 32'd0;
`endif

    bilinear_rd_arbiter #(
        .N_LANES  (N_LANES),
        .AW       (AW),
        .RD_LAT   (RD_LAT),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_flush          (i_flush),
        .req_valid        (req_valid),
        .req_lock         (req_lock),
        .req_addr0        (req_addr0),
        .req_addr1        (req_addr1),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data0        (rsp_data0),
        .rsp_data1        (rsp_data1),
        .mem_re           (mem_re),
        .mem_raddr0       (mem_raddr0),
        .mem_raddr1       (mem_raddr1),
        .mem_rdata0       (mem_rdata0),
        .mem_rdata1       (mem_rdata1),
        .o_stall_count    (o_stall_count),
        .o_lane_grants    (o_lane_grants),
        .o_conflict_count (o_conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        i_flush    = 1'b0;
        req_valid  = '0;
        req_lock   = '0;
        req_addr0  = {10'h2AB, 10'h005};
        req_addr1  = {10'h154, 10'h006};
        mem_rdata0 = '0;
        mem_rdata1 = '0;

        // Reset state
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_stall", o_stall_count, 0);
        chk("rst_grants", o_lane_grants, 0);
        chk("rst_conflict", o_conflict_count, 0);
        #10;
        rst_n = 1'b1;

        // 1: both lanes valid, no lock -> alternate starting at lane 0
        tick(); req_valid = 2'b11; #4;
        chk("t1_c0_ready", req_ready, 2'b01);
        chk("t1_c0_mem_re", mem_re, 1);
        chk("t1_c0_raddr0", mem_raddr0, 10'h005);
        chk("t1_c0_rsp", rsp_valid, 2'b00);
        tick(); #4;
        chk("t1_c1_ready", req_ready, 2'b10);
        chk("t1_c1_raddr1", mem_raddr1, 10'h154);
        chk("t1_c1_rsp", rsp_valid, 2'b00);
        tick(); #4;
        chk("t1_c2_ready", req_ready, 2'b01);
        chk("t1_c2_rsp", rsp_valid, 2'b01);
        tick(); #4;
        chk("t1_c3_ready", req_ready, 2'b10);
        chk("t1_c3_rsp", rsp_valid, 2'b10);
        tick(); req_valid = 2'b00; #4;
        chk("t1_c4_ready", req_ready, 2'b00);
        chk("t1_c4_mem_re", mem_re, 0);
        chk("t1_c4_raddr0", mem_raddr0, 0);
        chk("t1_c4_rsp", rsp_valid, 2'b01);
        tick(); #4;
        chk("t1_c5_rsp", rsp_valid, 2'b10);
        tick(); #4;
        chk("t1_c6_rsp", rsp_valid, 2'b00);

        // 2: lane 1 locked, lane 0 competing -> 4x lane 1, lane 0, lane 1
        tick(); req_valid = 2'b10; req_lock = 2'b10; #4;
        chk("t2_d0_ready", req_ready, 2'b10);
        chk("t2_d0_raddr0", mem_raddr0, 10'h2AB);
        tick(); req_valid = 2'b11; #4;
        chk("t2_d1_ready", req_ready, 2'b10);
        tick(); #4;
        chk("t2_d2_ready", req_ready, 2'b10);
        tick(); #4;
        chk("t2_d3_ready", req_ready, 2'b10);
        tick(); #4;
        chk("t2_d4_ready", req_ready, 2'b01);
        tick(); #4;
        chk("t2_d5_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00; req_lock = 2'b00;
        repeat (3) tick();

        // 3: single lane 0 read, RD_LAT=2
        req_valid = 2'b01; #4;
        chk("t3_mem_re", mem_re, 1);
        chk("t3_raddr0", mem_raddr0, 10'h005);
        chk("t3_raddr1", mem_raddr1, 10'h006);
        chk("t3_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00; mem_rdata0 = 32'hDEAD_BEEF; mem_rdata1 = 32'h1234_5678; #4;
        chk("t3_t1_rsp", rsp_valid, 2'b00);
        chk("t3_t1_mem_re", mem_re, 0);
        tick(); #4;
        chk("t3_t2_rsp", rsp_valid, 2'b01);
        chk("t3_t2_data0", rsp_data0, 32'hDEAD_BEEF);
        chk("t3_t2_data1", rsp_data1, 32'h1234_5678);
        tick(); #4;
        chk("t3_t3_rsp", rsp_valid, 2'b00);

        // 4: two accepts in flight, then flush
        tick(); req_valid = 2'b11; #4;
        chk("t4_f0_ready", req_ready, 2'b10);
        tick(); #4;
        chk("t4_f1_ready", req_ready, 2'b01);
        tick(); i_flush = 1'b1; #4;
        chk("t4_f2_ready", req_ready, 2'b00);
        chk("t4_f2_mem_re", mem_re, 0);
        chk("t4_f2_rsp", rsp_valid, 2'b00);
        tick(); i_flush = 1'b0; #4;
        chk("t4_f3_rsp", rsp_valid, 2'b00);
        chk("t4_f3_ready_lastkept", req_ready, 2'b10);
        tick(); req_valid = 2'b00; #4;
        chk("t4_f4_rsp", rsp_valid, 2'b00);
        tick(); #4;
        chk("t4_f5_rsp", rsp_valid, 2'b10);

        // 5: fresh reset, then 10 cycles with both lanes valid
        tick(); rst_n = 1'b0; #4;
        chk("t5_rst_stall", o_stall_count, 0);
        chk("t5_rst_rsp", rsp_valid, 2'b00);
        tick(); rst_n = 1'b1; req_valid = 2'b11;
        repeat (10) tick();
        req_valid = 2'b00; #4;
        chk("t5_stall", o_stall_count, 32'd10);
        chk("t5_conflict", o_conflict_count, EXP_CONFLICT);
        chk("t5_grants", o_lane_grants, EXP_GRANTS);

        // 6: async reset while a response is pending
        tick(); req_valid = 2'b01; #4;
        chk("t6_g0_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00; #4;
        chk("t6_g1_rsp", rsp_valid, 2'b00);
        tick(); #4;
        chk("t6_g2_rsp", rsp_valid, 2'b01);
        rst_n = 1'b0; #1;
        chk("t6_rst_rsp", rsp_valid, 2'b00);
        chk("t6_rst_stall", o_stall_count, 0);
        chk("t6_rst_grants", o_lane_grants, 0);
        #2;
        rst_n = 1'b1; req_valid = 2'b11; #1;
        chk("t6_first_grant", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
